chien_lambda1_lane_p32: RTL and testbench



---
 rtl/chien_lambda1_lane_p32.sv | 117 +++++++++++
 tb/tb_chien_lambda1_lane_p32.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/chien_lambda1_lane_p32.sv
// Chien-search lane for the Λ1 coefficient of the p=32 BCH decoder over GF(2^13).
// Presents α^1..α^8 times R each step and advances R by α^8 on every accepted step.
module chien_lambda1_lane_p32 (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [12:0]   lambda_in,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [12:0]   term1,
  output logic [12:0]   term2,
  output logic [12:0]   term3,
  output logic [12:0]   term4,
  output logic [12:0]   term5,
  output logic [12:0]   term6,
  output logic [12:0]   term7,
  output logic [12:0]   term8,
  output logic [10:0]   pos,
  output logic          busy,
  output logic          done
);

  localparam int unsigned M     = 13;
  localparam int unsigned STEPS = 1024;
  localparam int unsigned CW    = 11;
  localparam logic [M-1:0]  POLY_LOW = M'(13'h001B);
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [M-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [M-1:0]  pow_c [0:8];
  logic          accept_c;

  // Multiply by α: shift up one bit, fold α^13 back as α^4+α^3+α+1.
  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    mul_alpha = {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY_LOW : '0);
  endfunction

  always_comb begin
    pow_c[0] = r_q;
    for (int k = 1; k <= 8; k++) begin
      pow_c[k] = mul_alpha(pow_c[k-1]);
    end
  end

  assign accept_c = valid_q && out_ready;

  // Next-state: load wins over accept, so a load in RUN restarts without done.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = RUN;
      r_d     = lambda_in;
      cnt_d   = '0;
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end else if (state_q == RUN && accept_c) begin
      r_d = pow_c[8];
      if (cnt_q == LAST_CNT) begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pos       = cnt_q;
  assign term1     = pow_c[1];
  assign term2     = pow_c[2];
  assign term3     = pow_c[3];
  assign term4     = pow_c[4];
  assign term5     = pow_c[5];
  assign term6     = pow_c[6];
  assign term7     = pow_c[7];
  assign term8     = pow_c[8];

endmodule

// File: tb/tb_chien_lambda1_lane_p32.sv
// Directed bench for chien_lambda1_lane_p32 with hand-computed GF(2^13) expectations.
module tb_chien_lambda1_lane_p32;

  logic        clk;
  logic        rst;
  logic        load;
  logic [12:0] lambda_in;
  logic        out_ready;
  logic        out_valid;
  logic [12:0] term1, term2, term3, term4, term5, term6, term7, term8;
  logic [10:0] pos;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  chien_lambda1_lane_p32 dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .lambda_in (lambda_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .term1     (term1),
    .term2     (term2),
    .term3     (term3),
    .term4     (term4),
    .term5     (term5),
    .term6     (term6),
    .term7     (term7),
    .term8     (term8),
    .pos       (pos),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step with out_ready high until done, bounded.
  task automatic run_until_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [12:0] t1_hold, t8_hold;
    logic [12:0] exp_terms [0:7];
    logic [12:0] obs_terms [0:7];

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    load      = 1'b0;
    lambda_in = '0;
    out_ready = 1'b0;

    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_pos",   {21'd0, pos},       32'd0);
    check("rst_term1", {19'd0, term1},     32'd0);
    check("rst_term8", {19'd0, term8},     32'd0);
    rst = 1'b0;
    step();

    // Load α^0: terms are α^1..α^8.
    load = 1'b1; lambda_in = 13'h0001;
    step();
    load = 1'b0;
    check("load1_valid", {31'd0, out_valid}, 32'd1);
    check("load1_busy",  {31'd0, busy},      32'd1);
    check("load1_pos",   {21'd0, pos},       32'd0);
    exp_terms = '{13'h0002, 13'h0004, 13'h0008, 13'h0010, 13'h0020, 13'h0040, 13'h0080, 13'h0100};
    obs_terms = '{term1, term2, term3, term4, term5, term6, term7, term8};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("load1_term%0d", k + 1), {19'd0, obs_terms[k]}, {19'd0, exp_terms[k]});
    end

    // One accept: R = α^8.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("acc1_pos",   {21'd0, pos},   32'd1);
    check("acc1_term1", {19'd0, term1}, 32'h0200);
    check("acc1_term5", {19'd0, term5}, 32'h001B);
    check("acc1_term6", {19'd0, term6}, 32'h0036);

    // Load α^12 and stall for five cycles.
    load = 1'b1; lambda_in = 13'h1000;
    step();
    load = 1'b0;
    check("a12_term1", {19'd0, term1}, 32'h001B);
    check("a12_term2", {19'd0, term2}, 32'h0036);
    check("a12_term4", {19'd0, term4}, 32'h00D8);
    check("a12_term8", {19'd0, term8}, 32'h0D80);
    check("a12_pos",   {21'd0, pos},   32'd0);
    t1_hold = term1;
    t8_hold = term8;
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_term1", {19'd0, term1},     32'h001B);
      check("stall_term8", {19'd0, term8},     32'h0D80);
      check("stall_pos",   {21'd0, pos},       32'd0);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end

    // Full search from α^0: done after 1024 accepts, R ends at α^8192 = α^1.
    load = 1'b1; lambda_in = 13'h0001;
    step();
    load = 1'b0;
    out_ready = 1'b1;
    run_until_done(n);
    check("full_accepts", 32'(n),              32'd1024);
    check("full_done",    {31'd0, done},       32'd1);
    check("full_valid",   {31'd0, out_valid},  32'd0);
    check("full_busy",    {31'd0, busy},       32'd0);
    check("full_pos",     {21'd0, pos},        32'd0);
    check("full_term1",   {19'd0, term1},      32'h0004);
    step();
    check("full_done_once", {31'd0, done},     32'd0);
    check("full_idle_hold", {19'd0, term1},    32'h0004);

    // λ=0 search, then back-to-back load in the done cycle.
    load = 1'b1; lambda_in = 13'h0000;
    step();
    load = 1'b0;
    check("zero_term1", {19'd0, term1}, 32'd0);
    check("zero_term8", {19'd0, term8}, 32'd0);
    check("zero_valid", {31'd0, out_valid}, 32'd1);
    run_until_done(n);
    check("zero_accepts", 32'(n), 32'd1024);
    check("zero_final_term8", {19'd0, term8}, 32'd0);
    load = 1'b1; lambda_in = 13'h0001;
    step();
    load = 1'b0;
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_pos",   {21'd0, pos},       32'd0);
    check("b2b_term1", {19'd0, term1},     32'h0002);
    check("b2b_done",  {31'd0, done},      32'd0);

    // Abort: restart from the active search after ten accepts.
    for (int c = 0; c < 10; c++) step();
    check("abort_pre_pos", {21'd0, pos}, 32'd10);
    load = 1'b1; lambda_in = 13'h1000;
    step();
    load = 1'b0;
    check("abort_pos",   {21'd0, pos},       32'd0);
    check("abort_term1", {19'd0, term1},     32'h001B);
    check("abort_done",  {31'd0, done},      32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset in mid-cycle.
    step();
    step();
    check("pre_rst_pos", {21'd0, pos}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy",  {31'd0, busy},      32'd0);
    check("arst_done",  {31'd0, done},      32'd0);
    check("arst_pos",   {21'd0, pos},       32'd0);
    check("arst_term1", {19'd0, term1},     32'd0);
    check("arst_term8", {19'd0, term8},     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
